ahb_arbiter: RTL

Round-robin AHB bus arbiter that shares the single AHB address/data path between up to NUM_MASTERS bus masters, such as `ahb_master_improved` instances and the I2C bridge's DMA requester. It samples bus requests, tracks the current owner's burst so that ownership never changes mid-burst, and drives one-hot grants plus the `hmaster` index used by the address/write-data multiplexers and the slave side.

---
 rtl/ahb_arbiter_if.sv | 25 ++
 rtl/ahb_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// Bus-side signal bundle for the AHB arbiter: requests and owner transfer status in, grants out.
// The arbiter connects through the slave modport; requesters and testbenches use the master modport.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic                   hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [1:0]             hmaster;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter that never switches owner mid-burst.
// Optional locked-transfer support is enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic          Hclk,
  input logic          Hreset,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [1:0] DEFAULT_IDX  = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] GRANT_ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  logic [3:0]             beatsLeft_q, beatsLeft_d;
  logic                   incrOpen_q, incrOpen_d;
  logic                   lockHold_q, lockHold_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [1:0]             hmaster_q, hmaster_d;
  logic [1:0]             winner;
  logic [1:0]             scanIdx;
  logic                   arbOk;

  // Remaining beats after the accepted beat, i.e. burst length minus one.
  function automatic logic [3:0] burstRemaining(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burstRemaining = 4'd3;
      3'b100, 3'b101: burstRemaining = 4'd7;
      3'b110, 3'b111: burstRemaining = 4'd15;
      default:        burstRemaining = 4'd0;
    endcase
  endfunction

  always_comb begin
    beatsLeft_d = beatsLeft_q;
    incrOpen_d  = incrOpen_q;
    lockHold_d  = lockHold_q;
    if (bus.hready) begin
      if (bus.hresp || bus.htrans == TRANS_IDLE) begin
        beatsLeft_d = 4'd0;
        incrOpen_d  = 1'b0;
        lockHold_d  = 1'b0;
      end else if (bus.htrans == TRANS_NONSEQ) begin
        beatsLeft_d = burstRemaining(bus.hburst);
        incrOpen_d  = (bus.hburst == BURST_INCR);
`ifdef AHB_ARB_LOCK_EN
        lockHold_d  = bus.hlock[hmaster_q];
`endif
      end else if (bus.htrans == TRANS_SEQ && beatsLeft_q != 4'd0) begin
        beatsLeft_d = beatsLeft_q - 4'd1;
      end
    end
    // An undefined-length burst ends as soon as its owner stops requesting.
    if (!bus.hbusreq[hmaster_q]) begin
      incrOpen_d = 1'b0;
    end
`ifndef AHB_ARB_LOCK_EN
    lockHold_d = 1'b0;
`endif
  end

  // Scanning from the farthest offset down leaves the nearest requester after the owner as winner.
  always_comb begin
    winner  = DEFAULT_IDX;
    scanIdx = 2'd0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      scanIdx = 2'((int'(hmaster_q) + i) % NUM_MASTERS);
      if (bus.hbusreq[scanIdx]) begin
        winner = scanIdx;
      end
    end
  end

  always_comb begin
    arbOk     = bus.hready && (beatsLeft_d == 4'd0) && !incrOpen_d && !lockHold_d;
    hmaster_d = hmaster_q;
    hgrant_d  = hgrant_q;
    if (arbOk) begin
      hmaster_d = winner;
      hgrant_d  = GRANT_ONE << winner;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      beatsLeft_q <= 4'd0;
      incrOpen_q  <= 1'b0;
      lockHold_q  <= 1'b0;
      hmaster_q   <= DEFAULT_IDX;
      hgrant_q    <= GRANT_ONE << DEFAULT_IDX;
    end else begin
      beatsLeft_q <= beatsLeft_d;
      incrOpen_q  <= incrOpen_d;
      lockHold_q  <= lockHold_d;
      hmaster_q   <= hmaster_d;
      hgrant_q    <= hgrant_d;
    end
  end

`ifndef AHB_ARB_LOCK_EN
  logic unusedLock;
  assign unusedLock = ^bus.hlock;
`endif

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = lockHold_q;

endmodule
